// File: rtl/seg7_scan_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module : seg7_scan_monitor_if
//  Brief  : Bus-snoop inputs, display controls and segment/digit outputs
//           shared between the SoC bus side and seg7_scan_monitor.
//  Rev    : 1.0  initial release
// ============================================================================
interface seg7_scan_monitor_if #(
    parameter int DIGITS = 8
);
    logic              snoop_valid;
    logic              snoop_we;
    logic [31:0]       snoop_addr;
    logic [31:0]       snoop_data;
    logic [1:0]        mode;
    logic              freeze;
    logic [6:0]        seg;
    logic [DIGITS-1:0] dig_en;

    // The bus/SoC side drives the snoop and control signals.
    modport master (
        output snoop_valid,
        output snoop_we,
        output snoop_addr,
        output snoop_data,
        output mode,
        output freeze,
        input  seg,
        input  dig_en
    );

    modport slave (
        input  snoop_valid,
        input  snoop_we,
        input  snoop_addr,
        input  snoop_data,
        input  mode,
        input  freeze,
        output seg,
        output dig_en
    );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_monitor.sv
`default_nettype none
// ============================================================================
//  Module : seg7_scan_monitor
//  Brief  : Bus-snooping hex display controller; scans DIGITS hex nibbles of
//           the captured address/data or transfer count onto one multiplexed
//           7-segment bank. Optional macro SEG7_LEADING_ZERO_BLANK_EN blanks
//           leading zero digits.
//  Rev    : 1.0  initial release
// ============================================================================
module seg7_scan_monitor #(
    parameter int DIGITS         = 8,
    parameter int REFRESH_DIV    = 1024,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  wire logic            clk,
    input  wire logic            clr,
    seg7_scan_monitor_if.slave   bus
);

    localparam int c_DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int c_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(REFRESH_DIV - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DIGITS - 1);

    localparam logic [6:0]        c_SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [DIGITS-1:0] c_DIG_OFF = (DIG_ACTIVE_LOW != 0) ? {DIGITS{1'b1}}
                                                                    : {DIGITS{1'b0}};

    localparam logic [1:0] c_MODE_ADDR  = 2'b00;
    localparam logic [1:0] c_MODE_DATA  = 2'b01;
    localparam logic [1:0] c_MODE_COUNT = 2'b10;
    localparam logic [1:0] c_MODE_WDATA = 2'b11;

    logic [c_DIV_W-1:0] r_div_cnt;
    logic [c_IDX_W-1:0] r_idx;
    logic [31:0]        r_addr;
    logic [31:0]        r_data;
    logic [31:0]        r_xfer_cnt;
    logic [6:0]         r_seg;
    logic [DIGITS-1:0]  r_dig_en;

    logic [31:0]        w_value;
    logic [3:0]         w_nibble;
    logic [6:0]         w_seg_hi;
    logic [DIGITS-1:0]  w_onehot;
    logic               w_lead_blank;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Slot timer and digit index; idx steps on the last cycle of each slot.
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_div_cnt <= '0;
            r_idx     <= '0;
        end else if (r_div_cnt == c_DIV_LAST) begin
            r_div_cnt <= '0;
            r_idx     <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    // Capture path: freeze holds address/data but the transfer count always runs.
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_addr     <= '0;
            r_data     <= '0;
            r_xfer_cnt <= '0;
        end else begin
            if (bus.snoop_valid) begin
                r_xfer_cnt <= r_xfer_cnt + 32'd1;
            end
            if (bus.snoop_valid && !bus.freeze) begin
                r_addr <= bus.snoop_addr;
                if ((bus.mode != c_MODE_WDATA) || bus.snoop_we) begin
                    r_data <= bus.snoop_data;
                end
            end
        end
    end

    always_comb begin
        case (bus.mode)
            c_MODE_ADDR:  w_value = r_addr;
            c_MODE_DATA:  w_value = r_data;
            c_MODE_COUNT: w_value = r_xfer_cnt;
            default:      w_value = r_data;
        endcase
    end

    always_comb begin
        w_nibble = 4'h0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == c_IDX_W'(i)) begin
                w_nibble = w_value[4*i +: 4];
            end
        end
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // w_upper_zero[i] is set when nibbles i..DIGITS-1 are all zero.
    logic [DIGITS-1:0] w_upper_zero;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lead_zero
        assign w_upper_zero[gi] = ~|w_value[4*DIGITS-1:4*gi];
    end

    always_comb begin
        w_lead_blank = 1'b0;
        for (int i = 1; i < DIGITS; i++) begin
            if (r_idx == c_IDX_W'(i)) begin
                w_lead_blank = w_upper_zero[i];
            end
        end
    end
`else
    assign w_lead_blank = 1'b0;
`endif

    assign w_seg_hi = hex_to_seg(w_nibble);
    assign w_onehot = DIGITS'(1) << r_idx;

    // Digit enables drop for the first cycle of each slot so the previous
    // digit's segments never ghost onto the next one.
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_seg    <= c_SEG_OFF;
            r_dig_en <= c_DIG_OFF;
        end else begin
            if (w_lead_blank) begin
                r_seg <= c_SEG_OFF;
            end else begin
                r_seg <= (SEG_ACTIVE_LOW != 0) ? ~w_seg_hi : w_seg_hi;
            end
            if (r_div_cnt == '0) begin
                r_dig_en <= c_DIG_OFF;
            end else begin
                r_dig_en <= (DIG_ACTIVE_LOW != 0) ? ~w_onehot : w_onehot;
            end
        end
    end

    assign bus.seg    = r_seg;
    assign bus.dig_en = r_dig_en;

endmodule
`default_nettype wire

// File: doc/seg7_scan_monitor.md
Name: seg7_scan_monitor

Overview:
- Parametrised bus-snooping hex display controller that replaces per-digit static decoders with one time-multiplexed segment driver.
- Captures address/data of completed bus transfers, or counts them, and scans DIGITS hex digits onto shared segment lines with one-hot digit enables.
- Sits beside the bus in the SoC top and drives the board's multiplexed 7-segment bank.

Parameters:
- DIGITS, 8: number of displayed hex nibbles, legal 1..8; digit i shows value[4i+3:4i].
- REFRESH_DIV, 1024: clock cycles per digit slot, legal >= 2.
- SEG_ACTIVE_LOW, 1: 1 = seg outputs inverted (0 lights a segment).
- DIG_ACTIVE_LOW, 1: 1 = dig_en outputs inverted.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- clr  in  1  synchronous reset, active-low.
- snoop_valid  in  1  one-cycle strobe: a bus transfer completed this cycle.
- snoop_we  in  1  qualifies snoop_valid: 1 = write transfer.
- snoop_addr  in  32  transfer address.
- snoop_data  in  32  transfer data.
- mode  in  2  source select: 00 address, 01 data, 10 transfer count, 11 write-data only.
- freeze  in  1  1 = hold captured address/data registers.
- seg  out  7  segment lines, bit0 = a … bit6 = g, polarity per SEG_ACTIVE_LOW.
- dig_en  out  DIGITS  one-hot digit enable, polarity per DIG_ACTIVE_LOW.

Behaviour:
- Reset (clr == 0 at posedge): div_cnt = 0, idx = 0, addr_reg = data_reg = 0, xfer_cnt = 0. seg = all segments off and dig_en = all digits off, both at their inactive levels.
- Capture: at a posedge with snoop_valid = 1 and freeze = 0:
  - addr_reg <= snoop_addr.
  - data_reg <= snoop_data, except in mode 11, where data_reg updates only if snoop_we = 1.
- Freeze: freeze = 1 blocks addr_reg and data_reg updates. xfer_cnt still counts.
- xfer_cnt: 32-bit counter, +1 on every snoop_valid regardless of freeze or mode. Wraps from FFFFFFFF to 0.
- Display value: mode 00 = addr_reg, 01 = data_reg, 10 = xfer_cnt, 11 = data_reg.
- Mode changes take effect at the next registered output update; captured registers are not cleared.
- Scan timing:
  - div_cnt counts 0..REFRESH_DIV-1 and wraps.
  - At a posedge with div_cnt == REFRESH_DIV-1, idx advances; idx wraps from DIGITS-1 to 0.
- Anti-ghost blanking: for the cycle where div_cnt == 0, dig_en is all inactive. For the remaining REFRESH_DIV-1 cycles of the slot, exactly one dig_en bit (idx) is active.
- Output registers:
  - seg and dig_en are registered, computed from the current idx, div_cnt and display value.
  - Latency: a captured value appears on seg 2 cycles after the snoop_valid edge, if its digit is the active one.
- Decode table (hex → seg, active-high): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71. The output is inverted when SEG_ACTIVE_LOW = 1.
- Boundaries:
  - DIGITS = 1: idx stays 0, and the blanking cycle still occurs every slot.
  - snoop_valid during a blanking cycle is captured normally.
  - snoop_valid and clr = 0 in the same cycle: reset wins and nothing is captured.
  - Reset mid-slot restarts scanning at digit 0.

Optional Feature:
- Macro SEG7_LEADING_ZERO_BLANK_EN.
- Defined: a digit i > 0 is blanked (seg all off, dig_en still active) when all nibbles i..DIGITS-1 of the display value are zero. Digit 0 is never blanked, so value 0 shows a single "0".
- Undefined: all digits always show their nibble, including leading zeros.

Test Plan:
- Reset, then the first displayed digit: with clr = 0 for 2 cycles, then released (DIGITS = 8, REFRESH_DIV = 4, both polarities active-low) → seg = 7F and dig_en = FF during reset. First active slot shows dig_en = FE and seg = ~3F = 40.
- Address capture: snoop_valid with addr 0x1234ABCD, mode 00 → across one scan frame, digits 0..7 show D,C,B,A,4,3,2,1. On digit 0, seg = ~5E = 21 two cycles after the strobe.
- Freeze and count: freeze = 1, three strobes with addr 0xFFFFFFFF → mode 00 still shows the prior 0x1234ABCD. Mode 10 shows 00000004.
- Write-only data: mode 11 with a read (data 0xDEAD0000) then a write (data 0x0000BEEF) → display 0000BEEF. The read never appears.
- Counter wrap and blanking: preload xfer_cnt to FFFFFFFF via 2^32-1 strobes (or a force), then one more strobe → display 00000000. Every slot's div_cnt = 0 cycle has dig_en = FF.
- Leading-zero blanking (macro defined): data 0x000000A5 in mode 01 → digits 2..7 have seg = 7F, digit 1 = ~77, digit 0 = ~6D. Value 0 shows only digit 0 = ~3F.
